// File: rtl/vid_timing_pkg.sv
// Shared types and constants for the video output timing generator.
//   vid_timing_t : one axis of display timing (active / front porch / sync / back porch)
//   H_640, V_480 : default 640x480@60 timing
//   RGB_*        : colour-bar palette, bar_rgb() maps a bar index to its colour
package vid_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vid_timing_t;

  localparam vid_timing_t H_640 = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam vid_timing_t V_480 = '{active: 480, fp: 10, sync: 2,  bp: 33};

  localparam int unsigned DEF_CNT_W   = 12;
  localparam int unsigned RGB_W       = 24;
  localparam int unsigned FIFO_W      = 32;
  localparam int unsigned FRAME_CNT_W = 16;

  localparam logic [RGB_W-1:0] RGB_WHITE   = 24'hFF_FF_FF;
  localparam logic [RGB_W-1:0] RGB_YELLOW  = 24'hFF_FF_00;
  localparam logic [RGB_W-1:0] RGB_CYAN    = 24'h00_FF_FF;
  localparam logic [RGB_W-1:0] RGB_GREEN   = 24'h00_FF_00;
  localparam logic [RGB_W-1:0] RGB_MAGENTA = 24'hFF_00_FF;
  localparam logic [RGB_W-1:0] RGB_RED     = 24'hFF_00_00;
  localparam logic [RGB_W-1:0] RGB_BLUE    = 24'h00_00_FF;
  localparam logic [RGB_W-1:0] RGB_BLACK   = 24'h00_00_00;

  // Bar order left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [RGB_W-1:0] bar_rgb(input logic [2:0] idx);
    logic [RGB_W-1:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vid_hv_counter.sv
// Horizontal/vertical raster counters with region decode.
// Ports:
//   clk, rst_n   : pixel clock, async active-low reset
//   run          : low from reset until the first clock after release; counting
//                  starts at h=0,v=0 on the clock after that
//   h_cnt, v_cnt : raster position; h=0,v=0 is the first active pixel
//   active_c     : position is inside the active window
//   hsync_c      : h in the sync region (polarity-free)
//   vsync_c      : v in the sync region (polarity-free)
//   origin_c     : position is the frame origin
//   frame_end_c  : last pixel of the frame (v wraps on the next clock)
module vid_hv_counter
  import vid_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_640.active,
  parameter int unsigned H_FP     = H_640.fp,
  parameter int unsigned H_SYNC   = H_640.sync,
  parameter int unsigned H_BP     = H_640.bp,
  parameter int unsigned V_ACTIVE = V_480.active,
  parameter int unsigned V_FP     = V_480.fp,
  parameter int unsigned V_SYNC   = V_480.sync,
  parameter int unsigned V_BP     = V_480.bp,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             run,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active_c,
  output logic             hsync_c,
  output logic             vsync_c,
  output logic             origin_c,
  output logic             frame_end_c
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic line_end_c;

  // Region decode.
  always_comb begin
    line_end_c  = run && (h_cnt == H_LAST);
    frame_end_c = line_end_c && (v_cnt == V_LAST);
    active_c    = run && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    hsync_c     = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    vsync_c     = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    origin_c    = run && (h_cnt == '0) && (v_cnt == '0);
  end

  // Raster counters; the first clock after reset release only arms run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      run <= 1'b1;
    end else if (line_end_c) begin
      h_cnt <= '0;
      v_cnt <= frame_end_c ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vid_out_timing.sv
// Display timing generator draining the DDR read-channel FIFO.
// Ports:
//   clk, rst_n     : pixel clock (= FIFO read clock), async active-low reset
//   fifo_data_i    : FIFO dout, valid one clock after fifo_rden_o; [23:0] = RGB888
//   fifo_empty_i   : FIFO empty flag
//   pat_en_i       : (VID_TEST_PATTERN_EN only) colour-bar select, sampled at frame origin
//   fifo_rden_o    : FIFO read enable, one clock ahead of de_o
//   fval_o         : frame valid to the DDR read channel; rises at vsync start,
//                    falls after the last active pixel
//   hsync_o/vsync_o: syncs, polarity from SYNC_POL
//   de_o, rgb_o    : data enable and pixel
//   underflow_o    : sticky read-while-empty flag, cleared on the fval_o rise
//   frame_cnt_o    : completed frames, wraps
// Build option: define VID_TEST_PATTERN_EN to add the colour-bar generator.
module vid_out_timing
  import vid_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_640.active,
  parameter int unsigned H_FP     = H_640.fp,
  parameter int unsigned H_SYNC   = H_640.sync,
  parameter int unsigned H_BP     = H_640.bp,
  parameter int unsigned V_ACTIVE = V_480.active,
  parameter int unsigned V_FP     = V_480.fp,
  parameter int unsigned V_SYNC   = V_480.sync,
  parameter int unsigned V_BP     = V_480.bp,
  parameter int unsigned SYNC_POL = 0,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  // Reset value of frame_cnt_o; left at 0 except to exercise the wrap.
  parameter logic [15:0] FRAME_CNT_RST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fifo_data_i,
  input  logic        fifo_empty_i,
`ifdef VID_TEST_PATTERN_EN
  input  logic        pat_en_i,
`endif
  output logic        fifo_rden_o,
  output logic        fval_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic [23:0] rgb_o,
  output logic        underflow_o,
  output logic [15:0] frame_cnt_o
);

  localparam logic SYNC_ACT = 1'(SYNC_POL);
  localparam logic [CNT_W-1:0] FVAL_SET_V = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] FVAL_CLR_V = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] FVAL_CLR_H = CNT_W'(H_ACTIVE);

  logic             run;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             active_c;
  logic             hsync_c;
  logic             vsync_c;
  logic             origin_c;
  logic             frame_end_c;

  vid_hv_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CNT_W(CNT_W)
  ) u_hv (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .active_c    (active_c),
    .hsync_c     (hsync_c),
    .vsync_c     (vsync_c),
    .origin_c    (origin_c),
    .frame_end_c (frame_end_c)
  );

  logic        fval_set_c;
  logic        fval_clr_c;
  logic        pat_c;
  logic        uf_c;
  logic        uf_slot_q;
  logic [23:0] fifo_rgb_c;
  logic        unused_hi;

  // fval rises at vsync start (prefetch window) and drops right after the last read's pixel.
  assign fval_set_c = run && (v_cnt == FVAL_SET_V) && (h_cnt == '0);
  assign fval_clr_c = run && (v_cnt == FVAL_CLR_V) && (h_cnt == FVAL_CLR_H);

`ifdef VID_TEST_PATTERN_EN
  localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

  logic             pat_q;
  logic             pat_dly_q;
  logic [23:0]      bar_q;
  logic [CNT_W-1:0] bar_div_c;
  logic [2:0]       bar_idx_c;

  // Pattern select only changes at the origin, so a frame is never mixed.
  assign pat_c     = origin_c ? pat_en_i : pat_q;
  assign bar_div_c = h_cnt / CNT_W'(BAR_W);
  assign bar_idx_c = (bar_div_c > CNT_W'(7)) ? 3'd7 : bar_div_c[2:0];

  // Bar colour registered alongside de_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q     <= 1'b0;
      pat_dly_q <= 1'b0;
      bar_q     <= '0;
    end else begin
      if (origin_c) pat_q <= pat_en_i;
      pat_dly_q <= pat_c;
      bar_q     <= active_c ? bar_rgb(bar_idx_c) : '0;
    end
  end
`else
  logic unused_origin;
  assign pat_c         = 1'b0;
  assign unused_origin = origin_c;
`endif

  assign fifo_rden_o = active_c && !pat_c;
  assign uf_c        = fifo_rden_o && fifo_empty_i;
  assign unused_hi   = ^fifo_data_i[31:24];

  // Registered syncs, enable, frame valid, underflow and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_o     <= ~SYNC_ACT;
      vsync_o     <= ~SYNC_ACT;
      de_o        <= 1'b0;
      fval_o      <= 1'b0;
      underflow_o <= 1'b0;
      uf_slot_q   <= 1'b0;
      frame_cnt_o <= FRAME_CNT_RST;
    end else begin
      hsync_o   <= hsync_c ? SYNC_ACT : ~SYNC_ACT;
      vsync_o   <= vsync_c ? SYNC_ACT : ~SYNC_ACT;
      de_o      <= active_c;
      uf_slot_q <= uf_c;
      if (fval_set_c)      fval_o <= 1'b1;
      else if (fval_clr_c) fval_o <= 1'b0;
      if (uf_c)            underflow_o <= 1'b1;
      else if (fval_set_c) underflow_o <= 1'b0;
      if (frame_end_c)     frame_cnt_o <= frame_cnt_o + 16'd1;
    end
  end

  // FIFO dout is already a register; gate it with the registered qualifiers so the
  // pixel lands in the de_o cycle, and blank a slot whose read found the FIFO empty.
  assign fifo_rgb_c = (de_o && !uf_slot_q) ? fifo_data_i[23:0] : '0;

`ifdef VID_TEST_PATTERN_EN
  assign rgb_o = pat_dly_q ? bar_q : fifo_rgb_c;
`else
  assign rgb_o = fifo_rgb_c;
`endif

endmodule

// File: tb/tb_vid_out_timing.sv
`timescale 1ns/1ps
module tb_vid_out_timing;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  logic [31:0] fifo_data = 32'h0;
  logic        fifo_empty = 1'b0;

  logic rden, fval, hs, vs, de, uf;
  logic [23:0] rgb;
  logic [15:0] fc;
  logic rden_w, fval_w, hs_w, vs_w, de_w, uf_w;
  logic [23:0] rgb_w;
  logic [15:0] fc_w;

  vid_out_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0), .CNT_W(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fifo_data_i(fifo_data), .fifo_empty_i(fifo_empty),
`ifdef VID_TEST_PATTERN_EN
    .pat_en_i(1'b0),
`endif
    .fifo_rden_o(rden), .fval_o(fval), .hsync_o(hs), .vsync_o(vs), .de_o(de),
    .rgb_o(rgb), .underflow_o(uf), .frame_cnt_o(fc)
  );

  // Same timing with the frame counter preset near its wrap point.
  vid_out_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0), .CNT_W(12), .FRAME_CNT_RST(16'hFFFE)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .fifo_data_i(fifo_data), .fifo_empty_i(fifo_empty),
`ifdef VID_TEST_PATTERN_EN
    .pat_en_i(1'b0),
`endif
    .fifo_rden_o(rden_w), .fval_o(fval_w), .hsync_o(hs_w), .vsync_o(vs_w), .de_o(de_w),
    .rgb_o(rgb_w), .underflow_o(uf_w), .frame_cnt_o(fc_w)
  );

`ifdef VID_TEST_PATTERN_EN
  logic rden_p, fval_p, hs_p, vs_p, de_p, uf_p;
  logic [23:0] rgb_p;
  logic [15:0] fc_p;
  vid_out_timing dut_p (
    .clk(clk), .rst_n(rst_n), .fifo_data_i(32'h00123456), .fifo_empty_i(1'b1),
    .pat_en_i(1'b1),
    .fifo_rden_o(rden_p), .fval_o(fval_p), .hsync_o(hs_p), .vsync_o(vs_p), .de_o(de_p),
    .rgb_o(rgb_p), .underflow_o(uf_p), .frame_cnt_o(fc_p)
  );
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference raster and expected registered outputs.
  int   rh, rv;
  logic rrun;
  logic e_de, e_hs, e_vs, e_fval, e_uf;
  logic [15:0] e_fc;
  int   word = 0;
  int   empty_pix = -1;
  logic [23:0] sb[$];

  // Aggregate trackers.
  logic have_frame;
  int   fr_rd, fr_rise, last_fall, de_run;
  logic prev_hs, prev_de, prev_fval;

  typedef struct {
    int   c;
    logic rden, de, hs, vs, fval;
  } vec_t;
  vec_t tbl[17];

  function automatic int cur_c();
    return rv * HT + rh;
  endfunction

  task automatic step();
    int ph, pv;
    logic p_run, p_act, p_empty, exp_rden;
    logic [23:0] exp_rgb;
    ph = rh; pv = rv; p_run = rrun;
    p_act = p_run && (ph < HA) && (pv < VA);
    p_empty = fifo_empty;
    @(posedge clk); #1;
    e_de = p_act;
    e_hs = (ph >= HA + HF && ph < HA + HF + HS) ? 1'b0 : 1'b1;
    e_vs = (pv >= VA + VF && pv < VA + VF + VS) ? 1'b0 : 1'b1;
    if (p_run && pv == VA + VF && ph == 0) e_fval = 1'b1;
    else if (p_run && pv == VA - 1 && ph == HA) e_fval = 1'b0;
    if (p_act && p_empty) e_uf = 1'b1;
    else if (p_run && pv == VA + VF && ph == 0) e_uf = 1'b0;
    if (p_run && pv == VT - 1 && ph == HT - 1) e_fc = e_fc + 16'd1;
    // FIFO model: a read pops the next word, or nothing if empty.
    if (p_act) begin
      if (p_empty) begin
        sb.push_back(24'h0);
        empty_pix = -1;
      end else begin
        fifo_data = {8'hA5, word[23:0]};
        sb.push_back(word[23:0]);
        word++;
      end
    end
    if (!rrun) rrun = 1'b1;
    else if (rh == HT - 1) begin
      rh = 0;
      rv = (rv == VT - 1) ? 0 : rv + 1;
    end else rh++;
    fifo_empty = (empty_pix >= 0) && rrun && rh < HA && rv < VA && (rv * HA + rh == empty_pix);
    #3;
    cyc++;
    exp_rden = rrun && rh < HA && rv < VA;
    chk("rden", rden, exp_rden);
    chk("de", de, e_de);
    chk("hsync", hs, e_hs);
    chk("vsync", vs, e_vs);
    chk("fval", fval, e_fval);
    chk("underflow", uf, e_uf);
    chk("frame_cnt", fc, e_fc);
    chk("frame_cnt_preset", fc_w, 16'(e_fc + 16'hFFFE));
    if (e_de) begin
      if (sb.size() == 0) chk("sb_nonempty", 0, 1);
      else begin
        exp_rgb = sb.pop_front();
        chk("rgb_pixel", rgb, exp_rgb);
      end
    end else chk("rgb_blank", rgb, 24'h0);
    // Per-frame totals, checked at each origin closing a full frame.
    if (rrun && rh == 0 && rv == 0) begin
      if (have_frame) begin
        chk("frame_reads", fr_rd, HA * VA);
        chk("frame_fval_rises", fr_rise, 1);
      end
      have_frame = 1'b1; fr_rd = 0; fr_rise = 0;
    end
    if (rden) fr_rd++;
    if (fval && !prev_fval) fr_rise++;
    if (prev_hs && !hs) begin
      if (last_fall >= 0) chk("line_len", cyc - last_fall, HT);
      last_fall = cyc;
    end
    if (de) de_run++;
    else if (prev_de) begin
      chk("de_run_len", de_run, HA);
      de_run = 0;
    end
    prev_hs = hs; prev_de = de; prev_fval = fval;
  endtask

  task automatic wait_c(input int c, input string name);
    int n = 0;
    do begin
      step(); n++;
    end while (!(rrun && cur_c() == c) && n < 2 * FRAME);
    if (!(rrun && cur_c() == c)) chk({"wait_", name}, 0, 1);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    rrun = 1'b0; rh = 0; rv = 0;
    e_de = 0; e_hs = 1; e_vs = 1; e_fval = 0; e_uf = 0; e_fc = 16'h0;
    sb.delete(); have_frame = 0; fr_rd = 0; fr_rise = 0; last_fall = -1; de_run = 0;
    prev_hs = 1; prev_de = 0; prev_fval = 0; fifo_empty = 1'b0; empty_pix = -1;
    #1;
    chk({tag, "_hsync"}, hs, 1'b1);
    chk({tag, "_vsync"}, vs, 1'b1);
    chk({tag, "_de"}, de, 1'b0);
    chk({tag, "_rgb"}, rgb, 24'h0);
    chk({tag, "_rden"}, rden, 1'b0);
    chk({tag, "_fval"}, fval, 1'b0);
    chk({tag, "_uf"}, uf, 1'b0);
    chk({tag, "_fc"}, fc, 16'h0);
    chk({tag, "_fc_preset"}, fc_w, 16'hFFFE);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int early_hi;
    // {cycle in frame = v*14+h, rden, de, hsync, vsync, fval}
    tbl[0]  = '{0,  1, 0, 1, 1, 1};
    tbl[1]  = '{1,  1, 1, 1, 1, 1};
    tbl[2]  = '{8,  0, 1, 1, 1, 1};
    tbl[3]  = '{9,  0, 0, 1, 1, 1};
    tbl[4]  = '{10, 0, 0, 1, 1, 1};
    tbl[5]  = '{11, 0, 0, 0, 1, 1};
    tbl[6]  = '{12, 0, 0, 0, 1, 1};
    tbl[7]  = '{13, 0, 0, 1, 1, 1};
    tbl[8]  = '{14, 1, 0, 1, 1, 1};
    tbl[9]  = '{49, 1, 1, 1, 1, 1};
    tbl[10] = '{50, 0, 1, 1, 1, 1};
    tbl[11] = '{51, 0, 0, 1, 1, 0};
    tbl[12] = '{70, 0, 0, 1, 1, 0};
    tbl[13] = '{71, 0, 0, 1, 0, 1};
    tbl[14] = '{84, 0, 0, 1, 0, 1};
    tbl[15] = '{85, 0, 0, 1, 1, 1};
    tbl[16] = '{97, 0, 0, 1, 1, 1};

    #2;
    do_reset("rst0");

    // First frame: words 0..31 through the scoreboard.
    repeat (FRAME) step();

    // Boundary points of the next frame.
    for (int i = 0; i < 17; i++) begin
      wait_c(tbl[i].c, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_rden", i), rden, tbl[i].rden);
      chk($sformatf("tbl%0d_de", i), de, tbl[i].de);
      chk($sformatf("tbl%0d_hsync", i), hs, tbl[i].hs);
      chk($sformatf("tbl%0d_vsync", i), vs, tbl[i].vs);
      chk($sformatf("tbl%0d_fval", i), fval, tbl[i].fval);
    end

    // Empty FIFO for pixel 10 (v=1, h=2): its DE slot is cycle 17.
    empty_pix = 10;
    wait_c(0, "uf_origin");
    wait_c(17, "uf_slot");
    chk("uf_slot_de", de, 1'b1);
    chk("uf_slot_rgb", rgb, 24'h0);
    chk("uf_set", uf, 1'b1);
    wait_c(70, "uf_hold");
    chk("uf_hold", uf, 1'b1);
    wait_c(71, "uf_clear");
    chk("uf_cleared_on_fval", uf, 1'b0);
    chk("uf_clear_fval", fval, 1'b1);
    chk("frame_cnt_two", fc, 16'd2);
    chk("frame_cnt_wrapped", fc_w, 16'h0000);

    // Reset mid-frame at v=2, h=5.
    wait_c(33, "mid_pos");
    do_reset("rst_mid");
    early_hi = 0;
    for (int n = 0; n < 2 * FRAME && !(rrun && cur_c() == 70); n++) begin
      step();
      if (fval) early_hi++;
    end
    chk("mid_no_early_fval", early_hi, 0);
    step();
    chk("mid_fval_at_vsync", fval, 1'b1);
    chk("mid_fc", fc, 16'h0);
    wait_c(0, "mid_next_frame");
    wait_c(0, "mid_frame2");

`ifdef VID_TEST_PATTERN_EN
    begin
      logic [23:0] bars [8];
      int col, lines;
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      do_reset("rst_pat");
      col = 0; lines = 0;
      for (int n = 0; n < 1700 && lines < 2; n++) begin
        @(posedge clk); #4;
        chk("pat_rden", rden_p, 1'b0);
        chk("pat_uf", uf_p, 1'b0);
        if (de_p) begin
          chk($sformatf("pat_bar_col%0d", col), rgb_p, bars[col / 80]);
          col++;
        end else begin
          chk("pat_blank", rgb_p, 24'h0);
          if (col > 0) begin
            chk("pat_line_len", col, 640);
            col = 0; lines++;
          end
        end
      end
      chk("pat_lines_seen", lines, 2);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vid_out_timing.md
Name: vid_out_timing

Overview:
- Pixel-clock display timing generator that consumes the DDR read-channel FIFO. It produces HSYNC, VSYNC and DE for the VGA/HDMI transmitter.
- Drives the read channel's frame-valid (rising edge = DDR controller restarts read buffer) and the FIFO read-enable.
- Sits directly downstream of the DDR frame-buffer controller; its clock is the FIFO read clock.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync polarity; 0 = active-low pulses, 1 = active-high
- CNT_W, 12, width of h/v counters; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  pixel clock; also the read clock of the read FIFO
- rst_n  in  1  asynchronous active-low reset
- fifo_data_i  in  32  FIFO dout, standard mode (valid 1 clk after rden); pixel = [23:0] RGB888
- fifo_empty_i  in  1  FIFO empty flag
- fifo_rden_o  out  1  FIFO read enable
- fval_o  out  1  frame-valid to DDR read channel
- hsync_o  out  1  horizontal sync
- vsync_o  out  1  vertical sync
- de_o  out  1  data enable
- rgb_o  out  24  pixel data
- underflow_o  out  1  sticky: a read was issued while the FIFO was empty; cleared at frame start
- frame_cnt_o  out  16  completed-frame counter, wraps at 0xFFFF->0

Behaviour:
- Reset (async, rst_n=0): h_cnt=0, v_cnt=0, all outputs 0 except hsync_o/vsync_o = inactive level (~SYNC_POL... i.e. 1 when SYNC_POL=0).
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL analogous.
- Counters:
  - h_cnt increments every clk, wraps H_TOTAL-1 -> 0.
  - v_cnt increments on h wrap, wraps V_TOTAL-1 -> 0.
  - Frame origin: h_cnt=0, v_cnt=0 is the first active pixel.
- Region order per line and per frame: active, FP, SYNC, BP.
  - hsync active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync active for v_cnt in the same form using V_* parameters, whole lines.
- Registered outputs: hsync_o, vsync_o, de_o and rgb_o are registered and mutually aligned, delayed one clk after the counter state they decode.
- fifo_rden_o:
  - Combinational from counters: high when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
  - Runs one clk ahead of de_o, so FIFO dout lands in the same cycle as de_o=1.
  - Exactly H_ACTIVE*V_ACTIVE reads per frame.
- rgb_o: fifo_data_i[23:0] when de_o=1, else 0.
- fval_o (registered):
  - Rises on the clk where v_cnt enters V_ACTIVE+V_FP at h_cnt=0, i.e. at vsync start. This gives V_SYNC+V_BP lines of prefetch time for the controller's FIFO reset and refill.
  - Falls after the last active pixel of line V_ACTIVE-1.
  - Low throughout V_FP.
- Underflow:
  - If fifo_rden_o=1 and fifo_empty_i=1, the corresponding rgb_o is forced to 0 and underflow_o is set.
  - Timing is never stalled; the display never slips.
  - underflow_o clears on the fval_o rising edge, unless an underflow occurs in that same cycle (set wins).
- frame_cnt_o increments when v_cnt wraps V_TOTAL-1 -> 0.
- Reset mid-frame:
  - All state returns to reset values immediately.
  - Counting resumes at h=0, v=0 on the first clk after release.
  - fval_o stays low until the next vsync start, so the DDR controller never sees a partial-frame edge.

Optional Feature:
- Macro VID_TEST_PATTERN_EN.
- Defined:
  - Adds input port pat_en_i (1 bit, synchronous to clk).
  - When pat_en_i=1, rgb_o shows 8 vertical colour bars of width H_ACTIVE/8. Order: white, yellow, cyan, green, magenta, red, blue, black.
  - fifo_rden_o is held 0 and underflow detection is suppressed.
  - fval_o is unaffected.
  - pat_en_i is sampled only at frame origin, so no mid-frame switching.
- Not defined: port absent; the FIFO path is always used.

Decomposition:
- Package vid_timing_pkg:
  - timing record typedef (active/fp/sync/bp)
  - default 640x480@60 constants
  - colour-bar RGB constants
- One sub-module: vid_hv_counter (h/v counters, wrap, region decode). The top level adds read, fval, pipeline alignment and underflow logic.

Test Plan:
- All tests use small timing unless noted: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1.
- Free run after reset, FIFO never empty:
  - Expect 14-clk lines and 7-line frames.
  - Expect 32 rden pulses per frame.
  - Expect de_o high for 8 clks per active line, starting exactly 1 clk after rden.
- FIFO returns incrementing data 0,1,2...: rgb_o shows 0..31 in order across one frame, each pixel aligned with de_o=1; rgb_o=0 outside DE.
- fval edges:
  - fval_o rises at v_cnt=5, h_cnt=0 (+1 clk register).
  - fval_o falls after pixel 31.
  - DDR-side model sees exactly one rising edge per frame.
- Force fifo_empty_i=1 for pixel 10:
  - rgb_o=0 at that DE slot and underflow_o=1 afterwards.
  - underflow_o clears at the next fval rise.
- Assert rst_n=0 at v_cnt=2, h_cnt=5:
  - Outputs go to reset values asynchronously.
  - No fval rise until the vsync start after release.
  - frame_cnt_o=0.
- Default 640x480 parameters, with VID_TEST_PATTERN_EN and pat_en_i=1:
  - rden stays 0.
  - Colour bars change at every 80-pixel boundary.
  - frame_cnt_o wraps 0xFFFF->0 via preset.
